// File: rtl/legv8_control_unit_ts_if.sv
// Instruction/status in, control word out, between the IR/SR and the LEGv8 control unit.
interface legv8_control_unit_ts_if;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned STATUS_W = 5;
  localparam int unsigned CW_W     = 40;

  logic [INSTR_W-1:0]  instruction;
  logic [STATUS_W-1:0] status;
  logic [CW_W-1:0]     ControlWord;

  modport master (output instruction, output status, input ControlWord);
  modport slave  (input instruction, input status, output ControlWord);
endinterface

// File: rtl/legv8_control_unit_ts.sv
// Two-state FETCH/EXECUTE control unit for the LEGv8 multicycle datapath:
// decodes instruction and flags into the 40-bit datapath control word.
module legv8_control_unit_ts (
  input logic                    clock,
  input logic                    reset,
  legv8_control_unit_ts_if.slave bus
);
  typedef enum logic [1:0] {ST_FETCH = 2'b00, ST_EXECUTE = 2'b01} state_e;

  typedef struct packed {
    logic [2:0] rsvd;
    logic [1:0] state;
    logic [1:0] bo;
    logic [1:0] ks;
    logic       il;
    logic [1:0] ps;
    logic       status_load;
    logic       en_pc;
    logic       en_alu;
    logic       en_mem;
    logic       mem_write;
    logic       reg_write;
    logic       bsel;
    logic       c0;
    logic [4:0] fs;
    logic [4:0] sb;
    logic [4:0] sa;
    logic [4:0] da;
  } cw_t;

  localparam logic [4:0] FS_AND   = 5'b00000;
  localparam logic [4:0] FS_ORR   = 5'b00100;
  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SUB   = 5'b01001;
  localparam logic [4:0] FS_EOR   = 5'b01100;
  localparam logic [4:0] FS_LSL   = 5'b10000;
  localparam logic [4:0] FS_LSR   = 5'b10100;
  localparam logic [4:0] FS_PASSB = 5'b11000;
  localparam logic [1:0] PS_NEXT  = 2'b01;
  localparam logic [1:0] PS_OFFS  = 2'b10;
  localparam logic [1:0] PS_REG   = 2'b11;
  localparam logic [1:0] KS_DT    = 2'b01;
  localparam logic [1:0] KS_MOV   = 2'b10;
  localparam logic [1:0] KS_BR    = 2'b11;
  localparam logic [1:0] BO_A19   = 2'b01;

  state_e     state_q, state_d;
  cw_t        cw_c;
  logic [4:0] rd, rn, rm;
  logic       flag_z, flag_n, flag_c, flag_v, alu_zero;
  logic       cond_base, cond_c;
  logic       r_fmt, i_fmt, s_form;
  logic [4:0] alu_fs;
  logic       unused_shamt;

  assign rd           = bus.instruction[4:0];
  assign rn           = bus.instruction[9:5];
  assign rm           = bus.instruction[20:16];
  assign flag_z       = bus.status[0];
  assign flag_n       = bus.status[1];
  assign flag_c       = bus.status[2];
  assign flag_v       = bus.status[3];
  assign alu_zero     = bus.status[4];
  // The shift amount reaches the ALU through the constant generator, not the decoder.
  assign unused_shamt = ^bus.instruction[15:10];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // ARM condition codes: odd codes invert the even base, except 1111 which stays "always".
  always_comb begin
    cond_base = 1'b1;
    case (bus.instruction[3:1])
      3'd0:    cond_base = flag_z;
      3'd1:    cond_base = flag_c;
      3'd2:    cond_base = flag_n;
      3'd3:    cond_base = flag_v;
      3'd4:    cond_base = flag_c & ~flag_z;
      3'd5:    cond_base = (flag_n == flag_v);
      3'd6:    cond_base = ~flag_z & (flag_n == flag_v);
      default: cond_base = 1'b1;
    endcase
    cond_c = (bus.instruction[0] && (bus.instruction[3:1] != 3'b111)) ? ~cond_base : cond_base;
  end

  always_comb begin
    state_d = (state_q == ST_FETCH) ? ST_EXECUTE : ST_FETCH;
    cw_c    = '0;
    r_fmt   = 1'b0;
    i_fmt   = 1'b0;
    s_form  = 1'b0;
    alu_fs  = FS_AND;
    if (!reset) begin
      cw_c = '0;
    end else if (state_q == ST_FETCH) begin
      cw_c.il = 1'b1;
    end else begin
      cw_c.state = ST_EXECUTE;
      cw_c.ps    = PS_NEXT;
      casez (bus.instruction[31:21])
        11'b10001011000: begin r_fmt = 1'b1; alu_fs = FS_ADD; end
        11'b10101011000: begin r_fmt = 1'b1; alu_fs = FS_ADD; s_form = 1'b1; end
        11'b11001011000: begin r_fmt = 1'b1; alu_fs = FS_SUB; end
        11'b11101011000: begin r_fmt = 1'b1; alu_fs = FS_SUB; s_form = 1'b1; end
        11'b10001010000: begin r_fmt = 1'b1; alu_fs = FS_AND; end
        11'b11101010000: begin r_fmt = 1'b1; alu_fs = FS_AND; s_form = 1'b1; end
        11'b10101010000: begin r_fmt = 1'b1; alu_fs = FS_ORR; end
        11'b11001010000: begin r_fmt = 1'b1; alu_fs = FS_EOR; end
        11'b11010011011: begin i_fmt = 1'b1; alu_fs = FS_LSL; end
        11'b11010011010: begin i_fmt = 1'b1; alu_fs = FS_LSR; end
        11'b1001000100?: begin i_fmt = 1'b1; alu_fs = FS_ADD; end
        11'b1011000100?: begin i_fmt = 1'b1; alu_fs = FS_ADD; s_form = 1'b1; end
        11'b1101000100?: begin i_fmt = 1'b1; alu_fs = FS_SUB; end
        11'b1111000100?: begin i_fmt = 1'b1; alu_fs = FS_SUB; s_form = 1'b1; end
        11'b1001001000?: begin i_fmt = 1'b1; alu_fs = FS_AND; end
        11'b1111001000?: begin i_fmt = 1'b1; alu_fs = FS_AND; s_form = 1'b1; end
        11'b1011001000?: begin i_fmt = 1'b1; alu_fs = FS_ORR; end
        11'b1101001000?: begin i_fmt = 1'b1; alu_fs = FS_EOR; end
        11'b11111000010: begin
          cw_c.sa = rn; cw_c.bsel = 1'b1; cw_c.ks = KS_DT; cw_c.fs = FS_ADD;
          cw_c.en_mem = 1'b1; cw_c.reg_write = 1'b1; cw_c.da = rd;
        end
        11'b11111000000: begin
          cw_c.sa = rn; cw_c.sb = rd; cw_c.bsel = 1'b1; cw_c.ks = KS_DT;
          cw_c.fs = FS_ADD; cw_c.mem_write = 1'b1;
        end
        11'b110100101??: begin
          cw_c.fs = FS_PASSB; cw_c.bsel = 1'b1; cw_c.ks = KS_MOV;
          cw_c.da = rd; cw_c.reg_write = 1'b1; cw_c.en_alu = 1'b1;
        end
        11'b11010110000: begin
          cw_c.sa = rn; cw_c.sb = 5'd31; cw_c.fs = FS_ORR;
          cw_c.en_alu = 1'b1; cw_c.ps = PS_REG;
        end
        11'b000101?????: begin cw_c.ps = PS_OFFS; cw_c.ks = KS_BR; end
        11'b100101?????: begin
          cw_c.ps = PS_OFFS; cw_c.ks = KS_BR;
          cw_c.en_pc = 1'b1; cw_c.reg_write = 1'b1; cw_c.da = 5'd30;
        end
        11'b1011010????: begin
          // CBZ (bit 24 = 0) branches on zero, CBNZ (bit 24 = 1) on non-zero.
          cw_c.sb = rd; cw_c.fs = FS_PASSB; cw_c.bo = BO_A19; cw_c.ks = KS_BR;
          if (alu_zero != bus.instruction[24]) cw_c.ps = PS_OFFS;
        end
        11'b01010100???: begin
          if (cond_c) begin cw_c.ps = PS_OFFS; cw_c.bo = BO_A19; cw_c.ks = KS_BR; end
        end
        default: ;
      endcase
      if (r_fmt || i_fmt) begin
        cw_c.da          = rd;
        cw_c.sa          = rn;
        cw_c.fs          = alu_fs;
        cw_c.c0          = alu_fs[0];
        cw_c.reg_write   = 1'b1;
        cw_c.en_alu      = 1'b1;
        cw_c.status_load = s_form;
        if (r_fmt) cw_c.sb   = rm;
        else       cw_c.bsel = 1'b1;
      end
    end
  end

  assign bus.ControlWord = cw_c;
endmodule

// File: tb/tb_legv8_control_unit_ts.sv
// Randomised self-checking bench for legv8_control_unit_ts against an opcode-level model.
module tb_legv8_control_unit_ts;
  logic clock;
  logic reset;
  legv8_control_unit_ts_if bus ();

  legv8_control_unit_ts dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit exp_exec = 1'b0;

  typedef enum int {
    M_NOP, M_ADD, M_ADDS, M_SUB, M_SUBS, M_AND, M_ANDS, M_ORR, M_EOR, M_LSL, M_LSR,
    M_ADDI, M_ADDIS, M_SUBI, M_SUBIS, M_ANDI, M_ANDIS, M_ORRI, M_EORI,
    M_LDUR, M_STUR, M_MOVZ, M_BR, M_B, M_BL, M_CBZ, M_CBNZ, M_BCOND
  } mn_e;

  int unsigned op_val [27] = '{32'h458, 32'h558, 32'h658, 32'h758, 32'h450, 32'h750,
                               32'h550, 32'h650, 32'h69B, 32'h69A, 32'h7C2, 32'h7C0,
                               32'h6B0, 32'h244, 32'h2C4, 32'h344, 32'h3C4, 32'h248,
                               32'h3C8, 32'h2C8, 32'h348, 32'h1A5, 32'hB4, 32'hB5,
                               32'h54, 32'h05, 32'h25};
  int unsigned op_w   [27] = '{11, 11, 11, 11, 11, 11, 11, 11, 11, 11, 11, 11, 11,
                               10, 10, 10, 10, 10, 10, 10, 10, 9, 8, 8, 8, 6, 6};

  function automatic mn_e decode(input logic [31:0] ins);
    case (ins[31:21])
      11'h458: return M_ADD;   11'h558: return M_ADDS;
      11'h658: return M_SUB;   11'h758: return M_SUBS;
      11'h450: return M_AND;   11'h750: return M_ANDS;
      11'h550: return M_ORR;   11'h650: return M_EOR;
      11'h69B: return M_LSL;   11'h69A: return M_LSR;
      11'h7C2: return M_LDUR;  11'h7C0: return M_STUR;
      11'h6B0: return M_BR;
      default: ;
    endcase
    case (ins[31:22])
      10'h244: return M_ADDI;  10'h2C4: return M_ADDIS;
      10'h344: return M_SUBI;  10'h3C4: return M_SUBIS;
      10'h248: return M_ANDI;  10'h3C8: return M_ANDIS;
      10'h2C8: return M_ORRI;  10'h348: return M_EORI;
      default: ;
    endcase
    if (ins[31:23] == 9'h1A5) return M_MOVZ;
    case (ins[31:24])
      8'hB4: return M_CBZ; 8'hB5: return M_CBNZ; 8'h54: return M_BCOND;
      default: ;
    endcase
    if (ins[31:26] == 6'h05) return M_B;
    if (ins[31:26] == 6'h25) return M_BL;
    return M_NOP;
  endfunction

  // ALU function index * 4 + invert-B; C0 accompanies the subtract forms.
  function automatic longint alu_code(input mn_e m);
    case (m)
      M_AND, M_ANDS, M_ANDI, M_ANDIS: return 0;
      M_ORR, M_ORRI:                  return 4;
      M_ADD, M_ADDS, M_ADDI, M_ADDIS: return 8;
      M_SUB, M_SUBS, M_SUBI, M_SUBIS: return 9;
      M_EOR, M_EORI:                  return 12;
      M_LSL:                          return 16;
      M_LSR:                          return 20;
      default:                        return 24;
    endcase
  endfunction

  function automatic bit cond_holds(input int c, input logic [4:0] st);
    bit z, n, cf, v;
    z = st[0]; n = st[1]; cf = st[2]; v = st[3];
    case (c)
      0: return z;           1: return !z;
      2: return cf;          3: return !cf;
      4: return n;           5: return !n;
      6: return v;           7: return !v;
      8: return cf && !z;    9: return !(cf && !z);
      10: return n == v;     11: return n != v;
      12: return !z && (n == v);
      13: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [39:0] ref_cw(input logic [31:0] ins, input logic [4:0] st,
                                         input bit exec_ph, input bit in_rst);
    mn_e m;
    longint da, sa, sb, fs, c0, bsel, rw, mw, enm, ena, enpc, sl, ps, ks, bo, w;
    longint rd, rn, rm;
    if (in_rst) return 40'h0;
    if (!exec_ph) return 40'h00_4000_0000;
    m  = decode(ins);
    rd = longint'(ins[4:0]); rn = longint'(ins[9:5]); rm = longint'(ins[20:16]);
    da = 0; sa = 0; sb = 0; fs = 0; c0 = 0; bsel = 0; rw = 0; mw = 0; enm = 0;
    ena = 0; enpc = 0; sl = 0; ps = 1; ks = 0; bo = 0;
    case (m)
      M_ADD, M_ADDS, M_SUB, M_SUBS, M_AND, M_ANDS, M_ORR, M_EOR,
      M_LSL, M_LSR, M_ADDI, M_ADDIS, M_SUBI, M_SUBIS, M_ANDI, M_ANDIS, M_ORRI, M_EORI: begin
        da = rd; sa = rn; rw = 1; ena = 1; fs = alu_code(m);
        c0 = (fs == 9) ? 1 : 0;
        sl = (m == M_ADDS || m == M_SUBS || m == M_ANDS ||
              m == M_ADDIS || m == M_SUBIS || m == M_ANDIS) ? 1 : 0;
        if (m inside {M_ADD, M_ADDS, M_SUB, M_SUBS, M_AND, M_ANDS, M_ORR, M_EOR}) sb = rm;
        else bsel = 1;
      end
      M_LDUR:  begin sa = rn; bsel = 1; ks = 1; fs = 8; enm = 1; rw = 1; da = rd; end
      M_STUR:  begin sa = rn; sb = rd; bsel = 1; ks = 1; fs = 8; mw = 1; end
      M_MOVZ:  begin fs = 24; bsel = 1; ks = 2; da = rd; rw = 1; ena = 1; end
      M_BR:    begin sa = rn; sb = 31; fs = 4; ena = 1; ps = 3; end
      M_B:     begin ps = 2; ks = 3; end
      M_BL:    begin ps = 2; ks = 3; enpc = 1; rw = 1; da = 30; end
      M_CBZ:   begin sb = rd; fs = 24; bo = 1; ks = 3; ps = st[4] ? 2 : 1; end
      M_CBNZ:  begin sb = rd; fs = 24; bo = 1; ks = 3; ps = st[4] ? 1 : 2; end
      M_BCOND: if (cond_holds(int'(ins[3:0]), st)) begin ps = 2; bo = 1; ks = 3; end
      default: ;
    endcase
    w = da | (sa << 5) | (sb << 10) | (fs << 15) | (c0 << 20) | (bsel << 21) |
        (rw << 22) | (mw << 23) | (enm << 24) | (ena << 25) | (enpc << 26) |
        (sl << 27) | (ps << 28) | (ks << 31) | (bo << 33) | (64'sd1 << 35);
    return 40'(w);
  endfunction

  function automatic logic [31:0] rand_ins();
    int unsigned k, r;
    k = $urandom_range(0, 27);
    r = $urandom;
    if (k == 27) return r;
    return (r >> op_w[k]) | (op_val[k] << (32 - op_w[k]));
  endfunction

  task automatic tick();
    @(posedge clock);
    if (reset) exp_exec = !exp_exec;
    else       exp_exec = 1'b0;
    #1;
  endtask

  task automatic to_exec();
    if (!exp_exec) tick();
  endtask

  task automatic to_fetch();
    if (exp_exec) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.instruction = 32'h8B1F0040;
    bus.status = 5'h1F;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (bus.ControlWord !== 40'h0) begin
        fails++; $display("FAIL reset_hold: got %h want %h", bus.ControlWord, 40'h0);
      end
    end
    @(negedge clock);
    reset = 1'b1;
    exp_exec = 1'b0;
    #1;
    tests++;
    if (bus.ControlWord !== 40'h00_4000_0000) begin
      fails++; $display("FAIL reset_release_fetch: got %h want %h", bus.ControlWord, 40'h0040000000);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ins [3] = '{32'h8B1F0040, 32'hCB0003E0, 32'h00000000};
    logic [39:0] exp [3] = '{40'h08_1244_7C40, 40'h08_1254_83E0, 40'h08_1000_0000};
    for (int i = 0; i < 3; i++) begin
      to_exec();
      bus.instruction = ins[i];
      bus.status = 5'(i);
      #1;
      tests++;
      if (bus.ControlWord !== exp[i]) begin
        fails++; $display("FAIL directed_exec[%0d]: got %h want %h", i, bus.ControlWord, exp[i]);
      end
      tick();
      tests++;
      if (bus.ControlWord !== 40'h00_4000_0000) begin
        fails++; $display("FAIL directed_fetch[%0d]: got %h want %h", i, bus.ControlWord, 40'h0040000000);
      end
    end
  endtask

  task automatic test_cbz();
    for (int z = 1; z >= 0; z--) begin
      to_exec();
      bus.instruction = 32'hB4000101;
      bus.status = {1'(z), 4'h0};
      #1;
      tests++;
      if (bus.ControlWord[29:28] !== (z ? 2'b10 : 2'b01) || bus.ControlWord[22] !== 1'b0) begin
        fails++; $display("FAIL cbz_ps_z%0d: got ps=%b rw=%b want ps=%b rw=0", z,
                          bus.ControlWord[29:28], bus.ControlWord[22], z ? 2'b10 : 2'b01);
      end
      tests++;
      if (bus.ControlWord !== ref_cw(32'hB4000101, {1'(z), 4'h0}, 1'b1, 1'b0)) begin
        fails++; $display("FAIL cbz_word_z%0d: got %h want %h", z, bus.ControlWord,
                          ref_cw(32'hB4000101, {1'(z), 4'h0}, 1'b1, 1'b0));
      end
      tick();
    end
  endtask

  task automatic test_fetch_random();
    for (int i = 0; i < 20; i++) begin
      to_fetch();
      bus.instruction = rand_ins();
      bus.status = 5'($urandom);
      #1;
      tests++;
      if (bus.ControlWord !== 40'h00_4000_0000) begin
        fails++; $display("FAIL fetch_random ins=%h: got %h want %h", bus.instruction,
                          bus.ControlWord, 40'h0040000000);
      end
      tick();
    end
  endtask

  task automatic test_random_exec();
    logic [31:0] ins;
    logic [4:0]  st;
    logic [39:0] exp;
    for (int i = 0; i < 200; i++) begin
      to_exec();
      ins = rand_ins();
      st  = 5'($urandom);
      bus.instruction = ins;
      bus.status = st;
      #1;
      exp = ref_cw(ins, st, 1'b1, 1'b0);
      tests++;
      if (bus.ControlWord !== exp) begin
        fails++; $display("FAIL random_exec ins=%h st=%b: got %h want %h", ins, st, bus.ControlWord, exp);
      end
      tick();
    end
  endtask

  task automatic test_bcond();
    logic [31:0] ins;
    logic [4:0]  st;
    logic [39:0] exp;
    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < 4; k++) begin
        to_exec();
        ins = 32'h54000000 | ((32'($urandom) & 32'h7FFFF) << 5) | 32'(c);
        st  = 5'($urandom);
        bus.instruction = ins;
        bus.status = st;
        #1;
        exp = ref_cw(ins, st, 1'b1, 1'b0);
        tests++;
        if (bus.ControlWord !== exp) begin
          fails++; $display("FAIL bcond c=%0d st=%b: got %h want %h", c, st, bus.ControlWord, exp);
        end
        tick();
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    to_exec();
    bus.instruction = 32'h8B1F0040;
    bus.status = 5'h0;
    #1;
    tests++;
    if (bus.ControlWord !== 40'h08_1244_7C40) begin
      fails++; $display("FAIL midrst_pre: got %h want %h", bus.ControlWord, 40'h0812447C40);
    end
    #1;
    reset = 1'b0;
    #1;
    tests++;
    if (bus.ControlWord !== 40'h0) begin
      fails++; $display("FAIL midrst_async: got %h want %h", bus.ControlWord, 40'h0);
    end
    tick();
    tests++;
    if (bus.ControlWord !== 40'h0) begin
      fails++; $display("FAIL midrst_held: got %h want %h", bus.ControlWord, 40'h0);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    tests++;
    if (bus.ControlWord !== 40'h00_4000_0000) begin
      fails++; $display("FAIL midrst_release: got %h want %h", bus.ControlWord, 40'h0040000000);
    end
    tick();
    tests++;
    if (bus.ControlWord !== 40'h08_1244_7C40) begin
      fails++; $display("FAIL midrst_next_exec: got %h want %h", bus.ControlWord, 40'h0812447C40);
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] exp;
    bus.instruction = 32'hF84083E1;
    bus.status = 5'h0;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = ref_cw(32'hF84083E1, 5'h0, exp_exec, 1'b0);
      tests++;
      if (bus.ControlWord !== exp) begin
        fails++; $display("FAIL back_to_back[%0d]: got %h want %h", i, bus.ControlWord, exp);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.instruction = '0;
    bus.status = '0;
    test_reset();
    test_directed();
    test_cbz();
    test_fetch_random();
    test_random_exec();
    test_bcond();
    test_reset_mid_exec();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
